// File: rtl/fxp_square_if.sv
// Request/result bundle for the iterative fixed-point squarer.
// The requester drives start/in and watches the result side.
interface fxp_square_if #(
    parameter int WIDTH = 26,
    parameter int SHW   = 6
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             sticky;
    logic [SHW-1:0]   norm_shift;
    logic             zero;

    modport master (
        output start,
        output in,
        input  busy,
        input  done,
        input  out,
        input  sticky,
        input  norm_shift,
        input  zero
    );

    modport slave (
        input  start,
        input  in,
        output busy,
        output done,
        output out,
        output sticky,
        output norm_shift,
        output zero
    );
endinterface

// File: rtl/fxp_square.sv
// Iterative fixed-point squarer: shift-add the exact 2*WIDTH-bit square of a 0.xxx
// fraction, then normalise it so the MSB is set and report top bits plus sticky.
module fxp_square #(
    parameter int WIDTH = 26,
    parameter int BPC   = 2,
    parameter int SHW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    fxp_square_if.slave   sq
);
    localparam int ITER = WIDTH / BPC;
    localparam int PW   = 2 * WIDTH;
    localparam int CW   = $clog2(ITER + 1);
    localparam int SW   = $clog2(PW);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    cnt;

    logic [PW-1:0]    mcand_ext;
    logic [PW-1:0]    digit_ext;
    logic [SW-1:0]    shamt;
    logic [PW-1:0]    addend;
    logic [SHW-1:0]   lzc;
    logic [PW-1:0]    norm;

    logic [WIDTH-1:0] out_r;
    logic             sticky_r;
    logic [SHW-1:0]   norm_shift_r;
    logic             zero_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start is honoured in DONE as well as IDLE so results can stream back to back.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (sq.start) begin
                    accept     = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (cnt == CW'(ITER - 1)) begin
                    state_next = NORM;
                end
            end
            NORM: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (sq.start) begin
                    accept     = 1'b1;
                    state_next = MUL;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mcand_ext = {{WIDTH{1'b0}}, mcand};
        digit_ext = {{(PW - BPC){1'b0}}, mplier[BPC-1:0]};
        shamt     = SW'(cnt) * SW'(BPC);
        addend    = (mcand_ext * digit_ext) << shamt;
    end

    // Highest set bit wins; an all-zero accumulator leaves the shift at zero.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < PW; i++) begin
            if (acc[i]) begin
                lzc = SHW'(PW - 1 - i);
            end
        end
        norm = acc << lzc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            out_r        <= '0;
            sticky_r     <= 1'b0;
            norm_shift_r <= '0;
            zero_r       <= 1'b0;
        end else begin
            if (accept) begin
                mcand  <= sq.in;
                mplier <= sq.in;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= acc + addend;
                mplier <= mplier >> BPC;
                cnt    <= cnt + CW'(1);
            end
            if (state == NORM) begin
                out_r        <= norm[PW-1:WIDTH];
                sticky_r     <= |norm[WIDTH-1:0];
                norm_shift_r <= lzc;
                zero_r       <= (acc == '0);
            end
        end
    end

    assign sq.busy       = busy;
    assign sq.done       = done;
    assign sq.out        = out_r;
    assign sq.sticky     = sticky_r;
    assign sq.norm_shift = norm_shift_r;
    assign sq.zero       = zero_r;
endmodule

// File: tb/tb_fxp_square.sv
// Bench for fxp_square: directed vectors, a per-cycle compare against an arithmetic
// model of the square, and literal checks for latency, back-to-back and abort.
module tb_fxp_square;
    localparam int WIDTH = 26;
    localparam int BPC   = 2;
    localparam int SHW   = 6;
    localparam int ITER  = WIDTH / BPC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    fxp_square_if #(.WIDTH(WIDTH), .SHW(SHW)) sq ();

    fxp_square #(.WIDTH(WIDTH), .BPC(BPC), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               done_cyc;
    } exp_t;

    exp_t             pend[$];
    logic [WIDTH-1:0] held_out    = '0;
    logic             held_sticky = 1'b0;
    logic [SHW-1:0]   held_ns     = '0;
    logic             held_zero   = 1'b0;

    logic [WIDTH-1:0] m_out;
    logic             m_sticky;
    logic [SHW-1:0]   m_ns;
    logic             m_zero;
    logic             exp_done;
    logic             exp_busy;

    task automatic check_value(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Square by plain multiplication, then slide left until the top bit is set.
    function automatic void model(input logic [WIDTH-1:0] x, output logic [WIDTH-1:0] o,
                                  output logic s, output logic [SHW-1:0] ns, output logic z);
        logic [2*WIDTH-1:0] p;
        p  = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, x};
        z  = (p == '0);
        ns = '0;
        if (!z) begin
            while (!p[2*WIDTH-1]) begin
                p  = p << 1;
                ns = ns + 1'b1;
            end
        end
        o = p[2*WIDTH-1:WIDTH];
        s = |p[WIDTH-1:0];
    endfunction

    always begin
        @(negedge clk);
        #1;
        exp_done = (pend.size() > 0) && (pend[0].done_cyc == cyc);
        exp_busy = (pend.size() > 0) && (pend[0].done_cyc > cyc);
        check_value("busy", {63'b0, sq.busy}, {63'b0, exp_busy});
        check_value("done", {63'b0, sq.done}, {63'b0, exp_done});
        if (exp_done) begin
            model(pend[0].val, m_out, m_sticky, m_ns, m_zero);
            pend.delete(0);
            held_out    = m_out;
            held_sticky = m_sticky;
            held_ns     = m_ns;
            held_zero   = m_zero;
        end
        check_value("out", 64'(sq.out), 64'(held_out));
        check_value("sticky", {63'b0, sq.sticky}, {63'b0, held_sticky});
        check_value("norm_shift", 64'(sq.norm_shift), 64'(held_ns));
        check_value("zero", {63'b0, sq.zero}, {63'b0, held_zero});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] v, output int acc_cyc);
        exp_t e;
        sq.start = 1'b1;
        sq.in    = v;
        @(posedge clk);
        #1;
        sq.start   = 1'b0;
        acc_cyc    = cyc;
        e.val      = v;
        e.done_cyc = cyc + ITER + 1;
        pend.push_back(e);
    endtask

    task automatic wait_done(output int dcyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sq.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
        end
        dcyc = cyc;
    endtask

    task automatic check_output(input string name, input logic [WIDTH-1:0] o, input logic s,
                                input logic [SHW-1:0] ns, input logic z);
        check_value({name, " out"}, 64'(sq.out), 64'(o));
        check_value({name, " sticky"}, {63'b0, sq.sticky}, {63'b0, s});
        check_value({name, " norm_shift"}, 64'(sq.norm_shift), 64'(ns));
        check_value({name, " zero"}, {63'b0, sq.zero}, {63'b0, z});
    endtask

    logic [WIDTH-1:0] vec_in  [5] = '{26'h2000000, 26'h3FFFFFF, 26'h2000001, 26'h0000000, 26'h0000001};
    logic [WIDTH-1:0] vec_out [5] = '{26'h2000000, 26'h3FFFFFE, 26'h2000002, 26'h0000000, 26'h2000000};
    logic             vec_st  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [SHW-1:0]   vec_ns  [5] = '{6'd1, 6'd0, 6'd1, 6'd0, 6'd51};
    logic             vec_z   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int a;
        int d;
        int d1;
        int d2;
        sq.start = 1'b0;
        sq.in    = '0;

        model(26'h2000000, m_out, m_sticky, m_ns, m_zero);
        check_value("model half out", 64'(m_out), 64'h2000000);
        check_value("model half norm_shift", 64'(m_ns), 64'd1);
        model(26'h3FFFFFF, m_out, m_sticky, m_ns, m_zero);
        check_value("model max out", 64'(m_out), 64'h3FFFFFE);
        check_value("model max sticky", {63'b0, m_sticky}, 64'd1);

        repeat (3) tick();
        check_output("reset", '0, 1'b0, '0, 1'b0);
        check_value("reset busy", {63'b0, sq.busy}, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vec_in[i], a);
            wait_done(d);
            check_value("latency", 64'(d - a), 64'(ITER + 1));
            check_output("vector", vec_out[i], vec_st[i], vec_ns[i], vec_z[i]);
            repeat (2) tick();
        end

        // A start while busy must not disturb the operation in flight.
        apply_stimulus(26'h3FFFFFF, a);
        repeat (4) tick();
        sq.start = 1'b1;
        sq.in    = '0;
        @(posedge clk);
        #1;
        sq.start = 1'b0;
        wait_done(d1);
        check_output("ignored start", 26'h3FFFFFE, 1'b1, 6'd0, 1'b0);
        apply_stimulus(26'h2000001, a);
        wait_done(d2);
        check_value("back_to_back spacing", 64'(d2 - d1), 64'(ITER + 2));
        check_output("back_to_back", 26'h2000002, 1'b1, 6'd1, 1'b0);
        repeat (2) tick();

        // Abort in the middle of MUL.
        apply_stimulus(26'h3FFFFFF, a);
        repeat (6) tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        pend.delete();
        held_out    = '0;
        held_sticky = 1'b0;
        held_ns     = '0;
        held_zero   = 1'b0;
        tick();
        check_value("abort busy", {63'b0, sq.busy}, 64'd0);
        check_value("abort done", {63'b0, sq.done}, 64'd0);
        check_output("abort", '0, 1'b0, '0, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        apply_stimulus(26'h2000001, a);
        wait_done(d);
        check_value("latency after abort", 64'(d - a), 64'(ITER + 1));
        check_output("after abort", 26'h2000002, 1'b1, 6'd1, 1'b0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
